// File: rtl/xcvr_reset_seq_if.sv
// xcvr_reset_seq_if: transceiver status inputs and reset/ready outputs
// between the reset sequencer (master) and the PLL/PHY side (slave).
interface xcvr_reset_seq_if;
    logic pll_locked;
    logic pll_cal_busy;
    logic tx_cal_busy;
    logic rx_cal_busy;
    logic rx_is_lockedtodata;
    logic pll_powerdown;
    logic tx_analogreset;
    logic tx_digitalreset;
    logic rx_analogreset;
    logic rx_digitalreset;
    logic tx_ready;
    logic rx_ready;
    modport master (
        input  pll_locked, pll_cal_busy, tx_cal_busy, rx_cal_busy, rx_is_lockedtodata,
        output pll_powerdown, tx_analogreset, tx_digitalreset,
        output rx_analogreset, rx_digitalreset, tx_ready, rx_ready
    );
    modport slave (
        output pll_locked, pll_cal_busy, tx_cal_busy, rx_cal_busy, rx_is_lockedtodata,
        input  pll_powerdown, tx_analogreset, tx_digitalreset,
        input  rx_analogreset, rx_digitalreset, tx_ready, rx_ready
    );
endinterface

// File: rtl/xcvr_reset_seq.sv
// xcvr_reset_seq: independent TX/RX transceiver reset sequencers with input synchronisers.
// Optional macro XCVR_RST_LOCKLOSS_EN re-enters the lock wait on status loss.
module xcvr_reset_seq #(
    parameter int PLL_PD_CYCLES = 1000,
    parameter int TX_DIG_DELAY  = 100,
    parameter int RX_ANA_CYCLES = 1000,
    parameter int RX_LTD_CYCLES = 400,
    parameter int SYNC_LEN      = 2,
    parameter int CNT_W         = 16
) (
    input logic clk,
    input logic rst,
    xcvr_reset_seq_if.master xcvr
);
    typedef enum logic [1:0] {T_PD, T_LOCK, T_ANA, T_RDY} tx_state_t;
    typedef enum logic [1:0] {R_ANA, R_CDR, R_RDY} rx_state_t;
    localparam logic [CNT_W-1:0] PD_LAST  = CNT_W'(PLL_PD_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIG_LAST = CNT_W'(TX_DIG_DELAY - 1);
    localparam logic [CNT_W-1:0] ANA_LAST = CNT_W'(RX_ANA_CYCLES - 1);
    localparam logic [CNT_W-1:0] LTD_LAST = CNT_W'(RX_LTD_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    // bit order {ltd, rx_busy, tx_busy, pll_busy, locked}; busy stages reset to 1
    localparam logic [4:0] SYNC_RST = 5'b01110;
    logic [SYNC_LEN-1:0][4:0] sync_q;
    logic locked_s, pll_busy_s, tx_busy_s, rx_busy_s, ltd_s;
    tx_state_t tx_state;
    rx_state_t rx_state;
    logic [CNT_W-1:0] tx_cnt, rx_cnt;
    always_ff @(posedge clk) begin
        if (rst)
            sync_q <= {SYNC_LEN{SYNC_RST}};
        else
            sync_q <= {sync_q[SYNC_LEN-2:0], xcvr.rx_is_lockedtodata, xcvr.rx_cal_busy,
                       xcvr.tx_cal_busy, xcvr.pll_cal_busy, xcvr.pll_locked};
    end
    assign {ltd_s, rx_busy_s, tx_busy_s, pll_busy_s, locked_s} = sync_q[SYNC_LEN-1];
    // outputs change on the same edge as the state they decode
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state             <= T_PD;
            tx_cnt               <= '0;
            xcvr.pll_powerdown   <= 1'b1;
            xcvr.tx_analogreset  <= 1'b1;
            xcvr.tx_digitalreset <= 1'b1;
            xcvr.tx_ready        <= 1'b0;
        end else begin
            case (tx_state)
                T_PD:
                    if (tx_cnt == PD_LAST) begin
                        tx_state           <= T_LOCK;
                        tx_cnt             <= '0;
                        xcvr.pll_powerdown <= 1'b0;
                    end else
                        tx_cnt <= tx_cnt + ONE;
                T_LOCK:
                    if (locked_s && !pll_busy_s && !tx_busy_s) begin
                        tx_state            <= T_ANA;
                        tx_cnt              <= '0;
                        xcvr.tx_analogreset <= 1'b0;
                    end
                T_ANA:
`ifdef XCVR_RST_LOCKLOSS_EN
                    if (!locked_s) begin
                        tx_state            <= T_LOCK;
                        tx_cnt              <= '0;
                        xcvr.tx_analogreset <= 1'b1;
                    end else
`endif
                    if (tx_cnt == DIG_LAST) begin
                        tx_state             <= T_RDY;
                        xcvr.tx_digitalreset <= 1'b0;
                        xcvr.tx_ready        <= 1'b1;
                    end else
                        tx_cnt <= tx_cnt + ONE;
                T_RDY: begin
`ifdef XCVR_RST_LOCKLOSS_EN
                    if (!locked_s) begin
                        tx_state             <= T_LOCK;
                        tx_cnt               <= '0;
                        xcvr.tx_analogreset  <= 1'b1;
                        xcvr.tx_digitalreset <= 1'b1;
                        xcvr.tx_ready        <= 1'b0;
                    end
`endif
                end
                default: tx_state <= T_PD;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state             <= R_ANA;
            rx_cnt               <= '0;
            xcvr.rx_analogreset  <= 1'b1;
            xcvr.rx_digitalreset <= 1'b1;
            xcvr.rx_ready        <= 1'b0;
        end else begin
            case (rx_state)
                R_ANA:
                    if (rx_cnt == ANA_LAST && !rx_busy_s) begin
                        rx_state            <= R_CDR;
                        rx_cnt              <= '0;
                        xcvr.rx_analogreset <= 1'b0;
                    end else if (rx_cnt != ANA_LAST)
                        rx_cnt <= rx_cnt + ONE;
                R_CDR:
                    if (!ltd_s)
                        rx_cnt <= '0;
                    else if (rx_cnt == LTD_LAST) begin
                        rx_state             <= R_RDY;
                        xcvr.rx_digitalreset <= 1'b0;
                        xcvr.rx_ready        <= 1'b1;
                    end else
                        rx_cnt <= rx_cnt + ONE;
                R_RDY: begin
`ifdef XCVR_RST_LOCKLOSS_EN
                    if (!ltd_s) begin
                        rx_state             <= R_CDR;
                        rx_cnt               <= '0;
                        xcvr.rx_digitalreset <= 1'b1;
                        xcvr.rx_ready        <= 1'b0;
                    end
`endif
                end
                default: rx_state <= R_ANA;
            endcase
        end
    end
endmodule

// File: tb/tb_xcvr_reset_seq.sv
// tb_xcvr_reset_seq: directed scenarios for the transceiver reset sequencer.
// Expectations for lock-loss follow XCVR_RST_LOCKLOSS_EN when it is defined.
module tb_xcvr_reset_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int errors = 0;
    int checks = 0;
`ifdef XCVR_RST_LOCKLOSS_EN
    localparam bit LL = 1'b1;
`else
    localparam bit LL = 1'b0;
`endif
    xcvr_reset_seq_if xcvr();
    xcvr_reset_seq #(
        .PLL_PD_CYCLES(4), .TX_DIG_DELAY(8), .RX_ANA_CYCLES(10),
        .RX_LTD_CYCLES(5), .SYNC_LEN(2), .CNT_W(16)
    ) dut (.clk(clk), .rst(rst), .xcvr(xcvr));
    always #5 clk = ~clk;
    // {pll_powerdown, tx_ana, tx_dig, rx_ana, rx_dig, tx_ready, rx_ready}
    logic [6:0] obs;
    assign obs = {xcvr.pll_powerdown, xcvr.tx_analogreset, xcvr.tx_digitalreset,
                  xcvr.rx_analogreset, xcvr.rx_digitalreset, xcvr.tx_ready, xcvr.rx_ready};
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic pulse_rst(input int n);
        rst = 1'b1;
        repeat (n) tick();
        rst = 1'b0;
    endtask
    task automatic set_inputs(input logic lk, input logic pb, input logic tb, input logic rb, input logic ltd);
        xcvr.pll_locked = lk;
        xcvr.pll_cal_busy = pb;
        xcvr.tx_cal_busy = tb;
        xcvr.rx_cal_busy = rb;
        xcvr.rx_is_lockedtodata = ltd;
    endtask
    task automatic test_reset;
        pulse_rst(3);
        checks++;
        if (obs !== 7'b1111100) begin errors++; $display("FAIL reset_state got=%b exp=1111100", obs); end
    endtask
    task automatic test_power_up;
        logic [8:0] ltd_pat;
        ltd_pat = 9'b111110111;
        set_inputs(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (n == 3) begin
                checks++;
                if (xcvr.pll_powerdown !== 1'b1) begin errors++; $display("FAIL pd_high@3 got=%b exp=1", xcvr.pll_powerdown); end
            end
            if (n == 4) begin
                checks++;
                if ({xcvr.pll_powerdown, xcvr.tx_analogreset} !== 2'b01) begin errors++; $display("FAIL pd_fall@4 got=%b exp=01", {xcvr.pll_powerdown, xcvr.tx_analogreset}); end
            end
            if (n == 5) begin
                checks++;
                if ({xcvr.tx_analogreset, xcvr.tx_digitalreset} !== 2'b01) begin errors++; $display("FAIL tx_ana_fall@5 got=%b exp=01", {xcvr.tx_analogreset, xcvr.tx_digitalreset}); end
            end
            if (n == 12) begin
                checks++;
                if ({xcvr.tx_digitalreset, xcvr.tx_ready} !== 2'b10) begin errors++; $display("FAIL tx_dig@12 got=%b exp=10", {xcvr.tx_digitalreset, xcvr.tx_ready}); end
            end
            if (n == 13) begin
                checks++;
                if ({xcvr.tx_digitalreset, xcvr.tx_ready} !== 2'b01) begin errors++; $display("FAIL tx_ready@13 got=%b exp=01", {xcvr.tx_digitalreset, xcvr.tx_ready}); end
            end
            if (n == 22) begin
                checks++;
                if (xcvr.rx_analogreset !== 1'b1) begin errors++; $display("FAIL rx_ana_hold@22 got=%b exp=1", xcvr.rx_analogreset); end
            end
            if (n == 23) begin
                checks++;
                if ({xcvr.rx_analogreset, xcvr.rx_digitalreset} !== 2'b01) begin errors++; $display("FAIL rx_ana_fall@23 got=%b exp=01", {xcvr.rx_analogreset, xcvr.rx_digitalreset}); end
            end
            if (n == 33) begin
                checks++;
                if (xcvr.rx_ready !== 1'b0) begin errors++; $display("FAIL rx_ltd_restart@33 got=%b exp=0", xcvr.rx_ready); end
            end
            if (n == 34) begin
                checks++;
                if ({xcvr.rx_digitalreset, xcvr.rx_ready} !== 2'b01) begin errors++; $display("FAIL rx_ready@34 got=%b exp=01", {xcvr.rx_digitalreset, xcvr.rx_ready}); end
            end
            if (n == 20) xcvr.rx_cal_busy = 1'b0;
            if (n >= 23 && n <= 31) xcvr.rx_is_lockedtodata = ltd_pat[n-23];
        end
        checks++;
        if (obs !== 7'b0000011) begin errors++; $display("FAIL all_ready got=%b exp=0000011", obs); end
    endtask
    task automatic test_back_to_back;
        pulse_rst(1);
        checks++;
        if (obs !== 7'b1111100) begin errors++; $display("FAIL rst_pulse got=%b exp=1111100", obs); end
        test_power_up();
    endtask
    task automatic test_lock_wait;
        set_inputs(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        pulse_rst(2);
        for (int n = 1; n <= 81; n++) begin
            tick();
            if (n == 14 || n == 15) begin
                checks++;
                if (xcvr.rx_ready !== (n == 15)) begin errors++; $display("FAIL rx_fast@%0d got=%b exp=%b", n, xcvr.rx_ready, n == 15); end
            end
            if (n == 54 || n == 70 || n == 72) begin
                checks++;
                if ({xcvr.pll_powerdown, xcvr.tx_analogreset} !== 2'b01) begin errors++; $display("FAIL tx_lock_wait@%0d got=%b exp=01", n, {xcvr.pll_powerdown, xcvr.tx_analogreset}); end
            end
            if (n == 73) begin
                checks++;
                if (xcvr.tx_analogreset !== 1'b0) begin errors++; $display("FAIL tx_busy_drop@73 got=%b exp=0", xcvr.tx_analogreset); end
            end
            if (n == 80 || n == 81) begin
                checks++;
                if (xcvr.tx_ready !== (n == 81)) begin errors++; $display("FAIL tx_ready_wait@%0d got=%b exp=%b", n, xcvr.tx_ready, n == 81); end
            end
            if (n == 54) begin xcvr.pll_locked = 1'b1; xcvr.tx_cal_busy = 1'b1; end
            if (n == 70) xcvr.tx_cal_busy = 1'b0;
        end
    endtask
    task automatic test_lockloss;
        xcvr.pll_locked = 1'b0;
        for (int m = 1; m <= 24; m++) begin
            tick();
            if (m == 2) begin
                checks++;
                if (xcvr.tx_ready !== 1'b1) begin errors++; $display("FAIL ll_tx_early@2 got=%b exp=1", xcvr.tx_ready); end
            end
            if (m == 3) begin
                checks++;
                if ({xcvr.pll_powerdown, xcvr.tx_analogreset, xcvr.tx_digitalreset, xcvr.tx_ready} !== {1'b0, LL, LL, !LL})
                    begin errors++; $display("FAIL ll_tx_drop@3 got=%b exp=%b", {xcvr.pll_powerdown, xcvr.tx_analogreset, xcvr.tx_digitalreset, xcvr.tx_ready}, {1'b0, LL, LL, !LL}); end
            end
            if (m == 6) begin
                checks++;
                if (xcvr.tx_analogreset !== 1'b0) begin errors++; $display("FAIL ll_relock@6 got=%b exp=0", xcvr.tx_analogreset); end
            end
            if (m == 13 || m == 14) begin
                checks++;
                if (xcvr.tx_ready !== (m == 14 || !LL)) begin errors++; $display("FAIL ll_tx_ready@%0d got=%b exp=%b", m, xcvr.tx_ready, m == 14 || !LL); end
            end
            if (m == 17) begin
                checks++;
                if ({xcvr.rx_analogreset, xcvr.rx_digitalreset, xcvr.rx_ready} !== {1'b0, LL, !LL})
                    begin errors++; $display("FAIL ll_rx_drop@17 got=%b exp=%b", {xcvr.rx_analogreset, xcvr.rx_digitalreset, xcvr.rx_ready}, {1'b0, LL, !LL}); end
            end
            if (m == 23 || m == 24) begin
                checks++;
                if (xcvr.rx_ready !== (m == 24 || !LL)) begin errors++; $display("FAIL ll_rx_ready@%0d got=%b exp=%b", m, xcvr.rx_ready, m == 24 || !LL); end
            end
            if (m == 3) xcvr.pll_locked = 1'b1;
            if (m == 14) xcvr.rx_is_lockedtodata = 1'b0;
            if (m == 17) xcvr.rx_is_lockedtodata = 1'b1;
        end
    endtask
    initial begin
        set_inputs(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        test_reset();
        test_power_up();
        test_back_to_back();
        test_lock_wait();
        test_lockloss();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
